// File: rtl/text_loader.sv
// Boot loader: framed byte stream to little-endian text-memory words.
// Build option: LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte.
module text_loader #(
  parameter int         TEXT_BITS = 16,
  parameter logic [7:0] MAGIC     = 8'hA5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [TEXT_BITS-3:0] wr_address,
  output logic [31:0]          wr_data,
  output logic                 core_hold,
  output logic                 done,
  output logic                 error
);

  localparam int          AW  = TEXT_BITS - 2;
  localparam logic [32:0] CAP = 33'd1 << AW;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, COUNT, DATA, CHECK, DONE, ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, COUNT, DATA, DONE, ERROR
  } state_t;
`endif

  state_t        state, state_n;
  logic [1:0]    bidx;
  logic [31:0]   cnt;
  logic [23:0]   word;
  logic [AW-1:0] widx;
  logic          fire;
  logic          ready_n;
  logic          last_word;
  logic [31:0]   cnt_full;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    sum;
`endif

  assign fire      = in_valid && in_ready;
  assign cnt_full  = {in_data, cnt[23:0]};
  assign last_word = (32'(widx) == cnt - 32'd1);

  assign done      = (state == DONE);
  assign error     = (state == ERROR);
  assign core_hold = !done;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (fire && in_data == MAGIC)
          state_n = COUNT;
      end
      COUNT: begin
        if (fire && bidx == 2'd3) begin
          if (cnt_full == 32'd0)
`ifdef LOADER_CHECKSUM_EN
            state_n = CHECK;
`else
            state_n = DONE;
`endif
          else if ({1'b0, cnt_full} > CAP)
            state_n = ERROR;
          else
            state_n = DATA;
        end
      end
      DATA: begin
        if (fire && bidx == 2'd3 && last_word)
`ifdef LOADER_CHECKSUM_EN
          state_n = CHECK;
`else
          state_n = DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (fire)
          state_n = (in_data == sum) ? DONE : ERROR;
      end
`endif
      DONE:    state_n = DONE;
      ERROR:   state_n = ERROR;
      default: state_n = IDLE;
    endcase
  end

  assign ready_n = (state_n != DONE) && (state_n != ERROR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
      bidx       <= '0;
      cnt        <= '0;
      word       <= '0;
      widx       <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      state    <= state_n;
      in_ready <= ready_n;
      wr_en    <= 1'b0;
      if (fire && state == COUNT) begin
        bidx <= bidx + 2'd1;
        unique case (bidx)
          2'd0: cnt[7:0]   <= in_data;
          2'd1: cnt[15:8]  <= in_data;
          2'd2: cnt[23:16] <= in_data;
          default: cnt     <= cnt_full;
        endcase
      end
      if (fire && state == DATA) begin
        bidx <= bidx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        sum  <= sum + in_data;
`endif
        unique case (bidx)
          2'd0: word[7:0]   <= in_data;
          2'd1: word[15:8]  <= in_data;
          2'd2: word[23:16] <= in_data;
          default: begin
            wr_en      <= 1'b1;
            wr_data    <= {in_data, word};
            wr_address <= widx;
            widx       <= widx + 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/text_loader.md
Name: text_loader

Overview:
- Boot-time writer for instruction (text) memory: receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Issues one write per word into the text memory's write port at consecutive word addresses from 0.
- Holds the core in reset (core_hold) until the image is complete.
- Sits between the host byte link (UART receiver or testbench) and the text memory.

Parameters:
- TEXT_BITS, 16, byte-address width of text memory; capacity = 2**(TEXT_BITS-2) words.
- MAGIC, 8'hA5, frame start byte.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte; a byte transfers on a cycle with in_valid && in_ready.
- wr_en  output  1  text memory write strobe, one cycle per word.
- wr_address  output  TEXT_BITS-2  word address.
- wr_data  output  32  word, first received byte in bits [7:0].
- core_hold  output  1  keep core in reset; equals !done.
- done  output  1  image loaded.
- error  output  1  frame rejected; sticky until reset.

Behaviour:
- Reset values: in_ready=0, wr_en=0, wr_address=0, wr_data=0, done=0, error=0, core_hold=1. State goes to IDLE; byte counter, word counter, count register and checksum are cleared.
- A reset asserted mid-load aborts the load. Memory contents already written stay in place; the loader waits for a new frame.
- Frame format: MAGIC, then N as 4 bytes little-endian (word count), then N*4 data bytes, then an optional checksum byte (see Optional Feature).
- in_ready is a registered output:
  - 1 in IDLE, COUNT, DATA and CHECK.
  - 0 in DONE and ERROR.
  - Also 0 on the first cycle after reset.
- State IDLE:
  - Accepted byte == MAGIC -> COUNT.
  - Any other byte is discarded; stay in IDLE.
- State COUNT:
  - Collect 4 bytes into N, little-endian.
  - On the 4th byte:
    - N == 0 -> DONE; no writes are issued.
    - N > 2**(TEXT_BITS-2) -> ERROR; the comparison is done at full 32-bit width.
    - Otherwise -> DATA.
- State DATA:
  - A 2-bit byte index selects the byte lane of the word being assembled.
  - On the 4th accepted byte of a word, the registered outputs are set the next cycle:
    - wr_en=1 for exactly 1 cycle.
    - wr_data = assembled word.
    - wr_address = word index.
  - The word index increments after each write.
  - Write latency is 1 cycle after the final byte of a word.
  - After the final byte of word N-1:
    - -> DONE, so done rises in the same cycle as the last wr_en.
    - With the feature enabled, go to CHECK instead.
- The text memory always accepts writes; there is no write backpressure.
- in_valid gaps of any length are tolerated in every state; partial-word state is held.
- The word index never wraps: the N bound check guarantees the last address is 2**(TEXT_BITS-2)-1.
- State DONE: done=1, core_hold=0, in_ready=0. Terminal until reset.
- State ERROR: error=1, core_hold=1, in_ready=0. Terminal until reset.
- done and error are never both 1.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - Keep an 8-bit sum (mod 256) of all data bytes; MAGIC and count bytes are excluded.
  - After the final data byte, enter CHECK and accept 1 byte.
  - Byte equal to the sum -> DONE one cycle after acceptance.
  - Byte not equal -> ERROR.
  - Memory writes already issued are not undone.
  - For N == 0 the checksum byte is still expected and must be 8'h00.
- When undefined: no CHECK state and no checksum logic; the frame ends after the data bytes, as described in Behaviour.

Test Plan:
- Bytes 00,A5, N=2 (02 00 00 00), data 78 56 34 12 EF BE AD DE:
  - writes addr0=32'h12345678, then addr1=32'hDEADBEEF;
  - done=1 and core_hold=0 with the second wr_en;
  - in_ready=0 afterwards.
- Same frame with in_valid toggling every other cycle, plus 3-cycle gaps mid-word -> identical writes and values.
- A5, N=0 -> DONE with no wr_en. With the feature, trailing 00 is required; trailing 01 -> error=1.
- A5 with N = 2**(TEXT_BITS-2)+1 -> error=1 after the 4th count byte; no writes; in_ready=0.
- Reset asserted after 5 data bytes of an N=3 frame:
  - exactly 1 write has occurred;
  - all outputs return to reset values;
  - a fresh N=1 frame then writes addr0.
- LOADER_CHECKSUM_EN, N=1, data 01 02 03 04:
  - checksum 0A -> done;
  - checksum 0B -> error with addr0=32'h04030201 already written.
